request_arbiter_4_1: RTL and testbench

// - Shares one downstream resource between 4 requesters. Requester 0 has the highest priority (lowest index wins).
// - Registered one-hot grant plus encoded index. A grant is held until the owner releases it or a hold timeout fires.
// - Sits in front of shared encoder/mux datapaths, and drives their select lines and enable.

---
 rtl/request_arbiter_4_1.sv | 128 ++++++++++++
 tb/tb_request_arbiter_4_1.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/request_arbiter_4_1.sv
// Four-way request arbiter with registered one-hot grant, encoded index and hold timeout.
// Define ROUND_ROBIN_ARB_EN for rotating priority; the default build uses fixed priority (index 0 highest).
module request_arbiter_4_1 #(
  parameter int unsigned MAX_HOLD   = 16,
  parameter int unsigned HOLD_CNT_W = 8
) (
  input  logic       Clock_In,
  input  logic       Reset_In,
  input  logic       Enable_In,
  input  logic [3:0] Req_In,
  input  logic       Done_In,
  output logic [3:0] Grant_Out,
  output logic [1:0] Grant_Index_Out,
  output logic       Grant_Valid_Out,
  output logic       Timeout_Out
);

  typedef enum logic {
    IDLE,
    GRANTED
  } state_t;

  localparam bit                    HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(MAX_HOLD - 1);

  state_t                state_q, state_nxt;
  logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_nxt;
  logic [3:0]            grant_q, grant_nxt;
  logic [1:0]            index_q, index_nxt;
  logic                  timeout_q, timeout_nxt;

  logic [1:0]            search_base;
  logic [1:0]            winner;
  logic                  win_found;
  logic                  owner_req;
  logic                  release_exit;
  logic                  timeout_hit;

`ifdef ROUND_ROBIN_ARB_EN
  logic [1:0] rr_ptr_q;

  // Pointer names the first index searched; advancing on every grant also covers timeout-revoked owners.
  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      rr_ptr_q <= '0;
    end else if (state_q == IDLE && Enable_In && win_found) begin
      rr_ptr_q <= winner + 2'd1;
    end
  end

  assign search_base = rr_ptr_q;
`else
  assign search_base = '0;
`endif

  always_comb begin
    logic [1:0] cand;
    cand      = '0;
    winner    = '0;
    win_found = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      cand = search_base + k[1:0];
      if (!win_found && Req_In[cand]) begin
        winner    = cand;
        win_found = 1'b1;
      end
    end
  end

  assign owner_req    = |(Req_In & grant_q);
  assign release_exit = Done_In || !owner_req || !Enable_In;
  assign timeout_hit  = HOLD_EN && (hold_cnt_q == HOLD_LAST);

  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      grant_q    <= '0;
      index_q    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      hold_cnt_q <= hold_cnt_nxt;
      grant_q    <= grant_nxt;
      index_q    <= index_nxt;
      timeout_q  <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt    = state_q;
    hold_cnt_nxt = hold_cnt_q;
    grant_nxt    = grant_q;
    index_nxt    = index_q;
    timeout_nxt  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Enable_In && win_found) begin
          state_nxt    = GRANTED;
          hold_cnt_nxt = '0;
          grant_nxt    = 4'b0001 << winner;
          index_nxt    = winner;
        end
      end
      GRANTED: begin
        if (release_exit || timeout_hit) begin
          state_nxt    = IDLE;
          hold_cnt_nxt = '0;
          grant_nxt    = '0;
          // Timeout pulse only when no owner-side cause coincides.
          timeout_nxt  = timeout_hit && !release_exit;
        end else if (hold_cnt_q != '1) begin
          hold_cnt_nxt = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  assign Grant_Out       = grant_q;
  assign Grant_Index_Out = index_q;
  assign Grant_Valid_Out = (state_q == GRANTED);
  assign Timeout_Out     = timeout_q;

endmodule

// File: tb/tb_request_arbiter_4_1.sv
// Bench for request_arbiter_4_1: directed scenarios then random traffic against a cycle-level reference model.
// Two instances share stimulus: MAX_HOLD=4 and MAX_HOLD=1.
module tb_request_arbiter_4_1;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic       done;

  logic [3:0] g0, g1;
  logic [1:0] i0, i1;
  logic       v0, v1, t0, t1;

  int n_cmp  = 0;
  int n_fail = 0;

  int m_owner [2];
  int m_held  [2];
  int m_idx   [2];
  int m_ptr   [2];
  bit m_to    [2];
  int mh      [2] = '{4, 1};

  always #5 clk = ~clk;

  request_arbiter_4_1 #(.MAX_HOLD(4), .HOLD_CNT_W(8)) dut0 (
    .Clock_In(clk), .Reset_In(rst), .Enable_In(en), .Req_In(req), .Done_In(done),
    .Grant_Out(g0), .Grant_Index_Out(i0), .Grant_Valid_Out(v0), .Timeout_Out(t0)
  );

  request_arbiter_4_1 #(.MAX_HOLD(1), .HOLD_CNT_W(8)) dut1 (
    .Clock_In(clk), .Reset_In(rst), .Enable_In(en), .Req_In(req), .Done_In(done),
    .Grant_Out(g1), .Grant_Index_Out(i1), .Grant_Valid_Out(v1), .Timeout_Out(t1)
  );

  function automatic int pick(logic [3:0] r, int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1;
      m_held[d]  = 0;
      m_idx[d]   = 0;
      m_ptr[d]   = 0;
      m_to[d]    = 1'b0;
    end
  endtask

  // m_held counts clock edges the current grant has survived; exit when it reaches MAX_HOLD.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      m_to[d] = 1'b0;
      if (m_owner[d] < 0) begin
        if (en && req != 4'b0000) begin
          m_owner[d] = pick(req, m_ptr[d]);
          m_held[d]  = 1;
          m_idx[d]   = m_owner[d];
`ifdef ROUND_ROBIN_ARB_EN
          m_ptr[d]   = (m_owner[d] + 1) % 4;
`endif
        end
      end else begin
        bit other;
        bit tmo;
        other = done || !req[m_owner[d]] || !en;
        tmo   = (mh[d] != 0) && (m_held[d] == mh[d]);
        if (other || tmo) begin
          m_owner[d] = -1;
          m_held[d]  = 0;
          m_to[d]    = tmo && !other;
        end else begin
          m_held[d]++;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [3:0] eg [2];
    for (int d = 0; d < 2; d++) eg[d] = (m_owner[d] < 0) ? 4'b0000 : (4'b0001 << m_owner[d]);
    check("grant0", {4'b0, g0}, {4'b0, eg[0]});
    check("index0", {6'b0, i0}, 8'(m_idx[0]));
    check("valid0", {7'b0, v0}, {7'b0, m_owner[0] >= 0});
    check("tmo0",   {7'b0, t0}, {7'b0, m_to[0]});
    check("grant1", {4'b0, g1}, {4'b0, eg[1]});
    check("index1", {6'b0, i1}, 8'(m_idx[1]));
    check("valid1", {7'b0, v1}, {7'b0, m_owner[1] >= 0});
    check("tmo1",   {7'b0, t1}, {7'b0, m_to[1]});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    req  = 4'b0000;
    done = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    compare_all();
    check("reset_grant", {4'b0, g0}, 8'h00);

    // Single requester 2: one-cycle latency.
    req = 4'b0100;
    en  = 1'b1;
    step();
    check("first_grant", {4'b0, g0}, 8'h04);
    check("first_index", {6'b0, i0}, 8'd2);
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 4'b0000;
    step();

    // All requesting: priority order, release by Done_In.
    req = 4'b1111;
    step();
`ifndef ROUND_ROBIN_ARB_EN
    check("fixed_first", {4'b0, g0}, 8'h01);
`endif
    for (int n = 0; n < 5; n++) begin
      done = 1'b1;
      step();
      done = 1'b0;
      step();
    end
`ifndef ROUND_ROBIN_ARB_EN
    check("fixed_starve", {4'b0, g0}, 8'h01);
`endif
    req = 4'b0000;
    step();
    step();

    // Held request without release: timeout and regrant.
    req = 4'b0010;
    for (int n = 0; n < 12; n++) step();
    req = 4'b0000;
    step();
    step();

    // Owner 3 loses its grant when enable drops; no new grant while low.
    req = 4'b1000;
    step();
    check("own3_grant", {4'b0, g0}, 8'h08);
    en = 1'b0;
    step();
    check("en_drop_grant", {4'b0, g0}, 8'h00);
    check("en_drop_tmo", {7'b0, t0}, 8'h00);
    step();
    step();
    en = 1'b1;
    step();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      req  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) req = req | 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 4) == 0);
      en   = ($urandom_range(0, 9) != 0);
      step();
    end

    // Asynchronous reset between edges while granted.
    req  = 4'b0100;
    en   = 1'b1;
    done = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    #2;
    model_reset();
    compare_all();
    check("async_rst_valid", {7'b0, v0}, 8'h00);
    #1;
    rst = 1'b0;
    #1;
    compare_all();
    step();
    check("post_rst_grant", {4'b0, g0}, 8'h04);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
